// File: rtl/fc_pkg.sv
// Shared definitions for the FC classifier layers: layer FSM states, accumulator
// sizing and the accumulator-to-word saturation helper.
package fc_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FINAL = 2'd1,
        DONE  = 2'd2
    } fc_state_e;

    // Working width of the saturation helper; accumulators are sign-extended into it.
    localparam int SAT_W = 64;

    // Full-precision product plus enough headroom to sum every input element.
    function automatic int acc_width(input int word_size, input int input_size);
        return 2 * word_size + $clog2(input_size);
    endfunction

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] value,
        input int                      word_size
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (SAT_W'(1) <<< (word_size - 1)) - SAT_W'(1);
        min_v = -max_v - SAT_W'(1);
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One neuron of an FC layer: full-precision multiply-accumulate, then
// bias add, fixed-point rescale and saturation into the output score register.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 39
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        mac_en,
    input  logic                        load_out,
    input  logic signed [WORD_SIZE-1:0] in_data,
    input  logic signed [WORD_SIZE-1:0] in_w,
    input  logic signed [WORD_SIZE-1:0] bias,
    output logic signed [WORD_SIZE-1:0] out_y
);

    logic signed [2*WORD_SIZE-1:0] prod;
    logic signed [ACC_W-1:0]       acc_reg;
    logic signed [ACC_W-1:0]       sum;
    logic signed [ACC_W-1:0]       rescaled;

    assign prod = (2*WORD_SIZE)'(in_data) * (2*WORD_SIZE)'(in_w);

    // Bias is aligned to the product's 2*FRAC_BITS binary point before the add.
    assign sum      = acc_reg + (ACC_W'(bias) <<< FRAC_BITS);
    assign rescaled = sum >>> FRAC_BITS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            out_y   <= '0;
        end else begin
            if (clear) begin
                acc_reg <= '0;
            end else if (mac_en) begin
                acc_reg <= acc_reg + ACC_W'(prod);
            end
            if (load_out) begin
                out_y <= WORD_SIZE'(saturate(SAT_W'(rescaled), WORD_SIZE));
            end
        end
    end

endmodule

// File: rtl/fc_output_layer.sv
// Final FC layer: streams the feature vector through LAYER_SIZE parallel MAC lanes
// and hands the saturated score vector to the argmax stage via valid/ready.
module fc_output_layer
    import fc_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LAYER_SIZE = 10,
    parameter int INPUT_SIZE = 120,
    localparam int IDX_W     = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WORD_SIZE-1:0]                  in_data,
    input  logic [LAYER_SIZE-1:0][WORD_SIZE-1:0]  in_w,
    output logic [IDX_W-1:0]                      elem_idx,
    input  logic [LAYER_SIZE-1:0][WORD_SIZE-1:0]  bias,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LAYER_SIZE-1:0][WORD_SIZE-1:0]  out_y
);

    localparam int ACC_W = acc_width(WORD_SIZE, INPUT_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

    fc_state_e state_reg;
    fc_state_e state_next;
    logic      accept;
    logic      release_out;

    assign in_ready    = (state_reg == ACCUM);
    assign accept      = in_valid && in_ready;
    assign release_out = (state_reg == DONE) && out_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (accept && (elem_idx == LAST_IDX)) state_next = FINAL;
            FINAL:   state_next = DONE;
            DONE:    if (out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
            elem_idx  <= '0;
            out_valid <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (release_out) begin
                elem_idx <= '0;
            end else if (accept) begin
                elem_idx <= elem_idx + IDX_W'(1);
            end
            if (state_reg == FINAL) begin
                out_valid <= 1'b1;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LAYER_SIZE; gi++) begin : g_lane
            fc_mac_lane #(
                .WORD_SIZE (WORD_SIZE),
                .FRAC_BITS (FRAC_BITS),
                .ACC_W     (ACC_W)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear    (release_out),
                .mac_en   (accept),
                .load_out (state_reg == FINAL),
                .in_data  (in_data),
                .in_w     (in_w[gi]),
                .bias     (bias[gi]),
                .out_y    (out_y[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_fc_output_layer.sv
// Directed bench for fc_output_layer with a 4-element input vector and 10 lanes.
module tb_fc_output_layer;

    localparam int WS = 16;
    localparam int LS = 10;
    localparam int IS = 4;
    localparam int NV = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [WS-1:0]         in_data = '0;
    logic [LS-1:0][WS-1:0] in_w = '0;
    logic [1:0]            elem_idx;
    logic [LS-1:0][WS-1:0] bias = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [LS-1:0][WS-1:0] out_y;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IS-1:0][WS-1:0] data;
        logic [LS-1:0][WS-1:0] w;
        logic [LS-1:0][WS-1:0] bias;
        logic [LS-1:0][WS-1:0] exp;
    } vec_t;

    vec_t vecs [NV];

    fc_output_layer #(
        .WORD_SIZE  (WS),
        .FRAC_BITS  (8),
        .LAYER_SIZE (LS),
        .INPUT_SIZE (IS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_w      (in_w),
        .elem_idx  (elem_idx),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [LS*WS-1:0] act, input logic [LS*WS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Drives nbeats beats of vector vi; gaps inserts 1..3 idle cycles before each beat.
    task automatic feed(input int vi, input int nbeats, input bit gaps);
        bias = vecs[vi].bias;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                for (int g = 0; g < 1 + (b % 3); g++) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                    check("idx_hold_bubble", elem_idx, b);
                end
            end
            in_data  = vecs[vi].data[b];
            in_w     = vecs[vi].w;
            in_valid = 1'b1;
            check("beat_ready", in_ready, 1);
            check("beat_idx", elem_idx, b);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Called just after the last accepting edge: FINAL, then DONE with the result.
    task automatic finish_vector(input int vi);
        check("final_in_ready", in_ready, 0);
        check("final_out_valid", out_valid, 0);
        @(posedge clk); #1;
        check("done_out_valid", out_valid, 1);
        check("done_in_ready", in_ready, 0);
        check($sformatf("out_y_vec%0d", vi), out_y, vecs[vi].exp);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_out_valid", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
        check("hs_elem_idx", elem_idx, 0);
    endtask

    initial begin
        for (int k = 0; k < LS; k++) begin
            vecs[0].w[k] = 16'(k * 'h40);  vecs[0].bias[k] = '0;      vecs[0].exp[k] = 16'(k * 'h100);
            vecs[1].w[k] = 16'h0080;       vecs[1].bias[k] = 16'h0100; vecs[1].exp[k] = 16'h0000;
            vecs[2].w[k] = 16'h0080;       vecs[2].bias[k] = '0;      vecs[2].exp[k] = 16'hFF00;
            vecs[3].w[k] = 16'h7FFF;       vecs[3].bias[k] = '0;      vecs[3].exp[k] = 16'h7FFF;
            vecs[4].w[k] = 16'h8000;       vecs[4].bias[k] = '0;      vecs[4].exp[k] = 16'h8000;
            vecs[5].w[k] = 16'(k);         vecs[5].bias[k] = '0;      vecs[5].exp[k] = (k == 0) ? 16'h0000 : 16'hFFFF;
            vecs[6].w[k] = 16'h7FFF;       vecs[6].bias[k] = 16'(k * 'h123) - 16'h0400;
            vecs[6].exp[k] = vecs[6].bias[k];
            vecs[7].w[k] = 16'(k * 'h100); vecs[7].bias[k] = '0;      vecs[7].exp[k] = 16'(k * 'hA00);
        end
        for (int b = 0; b < IS; b++) begin
            vecs[0].data[b] = 16'h0100;
            vecs[1].data[b] = 16'hFF80;
            vecs[2].data[b] = 16'hFF80;
            vecs[3].data[b] = 16'h7FFF;
            vecs[4].data[b] = 16'h7FFF;
            vecs[5].data[b] = 16'hFFFF;
            vecs[6].data[b] = 16'h0000;
            vecs[7].data[b] = 16'((b + 1) * 'h100);
        end

        repeat (2) @(posedge clk);
        #1;
        check("por_out_valid", out_valid, 0);
        check("por_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            feed(i, IS, 1'b0);
            finish_vector(i);
            handshake();
        end

        // Bubbles between beats, then backpressure while in_valid stays high.
        feed(7, IS, 1'b1);
        finish_vector(7);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 16'h1234;
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_out_y", out_y, vecs[7].exp);
            check("bp_in_ready", in_ready, 0);
            check("bp_elem_idx", elem_idx, 0);
        end
        handshake();
        in_valid = 1'b0;
        feed(6, IS, 1'b0);
        finish_vector(6);

        // Asynchronous reset mid-cycle while a result is being held.
        #3 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, '0);
        check("rst_elem_idx", elem_idx, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset after two accepted beats must leave no residue.
        feed(3, 2, 1'b0);
        check("partial_idx", elem_idx, 2);
        #3 rst_n = 1'b0;
        #1;
        check("rst2_elem_idx", elem_idx, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        feed(0, IS, 1'b0);
        finish_vector(0);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
